// File: rtl/imm_gen_pipe_pkg.sv
// Shared encodings for the immediate generator: type codes, unsigned-select bit, occupancy states.
// Imported by imm_decode and imm_gen_pipe so no block hard-codes these values.
package imm_gen_pipe_pkg;

    localparam int IMM_TYPE_W  = 3;
    localparam int IMM_UNS_BIT = 3;

    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_NONE = 3'd0;
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE1     = 3'd1;  // U
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE2     = 3'd2;  // J
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE3     = 3'd3;  // I
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE4     = 3'd4;  // B
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE5     = 3'd5;  // S
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE6     = 3'd6;  // shift amount
    localparam logic [IMM_TYPE_W-1:0] IMM_TYPE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Purpose: combinational RISC-V immediate extraction and sign/zero extension to XLEN.
// Latency: 0 cycles. Backpressure: none, pure logic. Optional illegal flag under IMM_ILLEGAL_CHECK_EN.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [3:0]      imm_sel,
    output logic [XLEN-1:0] imm
`ifdef IMM_ILLEGAL_CHECK_EN
    ,
    output logic            illegal
`endif
);

    logic [IMM_TYPE_W-1:0] imm_type;
    logic                  sgn;
    logic [63:0]           wide;
    logic                  unused_bits;

    assign imm_type = imm_sel[IMM_TYPE_W-1:0];
    // Every signed type has its MSB at inst[31].
    assign sgn      = inst[31] & ~imm_sel[IMM_UNS_BIT];

    always_comb begin
        wide = '0;
        case (imm_type)
            IMM_TYPE1: wide = {{32{sgn}}, inst[31:12], 12'b0};
            IMM_TYPE2: wide = {{43{sgn}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_TYPE3: wide = {{52{sgn}}, inst[31:20]};
            IMM_TYPE4: wide = {{51{sgn}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_TYPE5: wide = {{52{sgn}}, inst[31:25], inst[11:7]};
            IMM_TYPE6: wide = {58'b0, (XLEN == 64) && inst[25], inst[24:20]};
            default:   wide = '0;
        endcase
    end

    assign imm         = wide[XLEN-1:0];
    assign unused_bits = ^{inst[6:0], wide};

`ifdef IMM_ILLEGAL_CHECK_EN
    assign illegal = (imm_type == IMM_TYPE_NONE) || (imm_type == IMM_TYPE_RSVD) ||
                     ((XLEN == 32) && (imm_type == IMM_TYPE6) && inst[25]);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: immediate generator behind a 2-entry skid FIFO; optional illegal output via IMM_ILLEGAL_CHECK_EN.
// Latency: 1 cycle from accept to out_valid when empty. Backpressure: in_ready = !FULL, registered only.
// Flush and reset empty the FIFO; reset also zeroes all stored entries.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [3:0]       imm_sel,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] tag_out
`ifdef IMM_ILLEGAL_CHECK_EN
    ,
    output logic             illegal
`endif
);

    // Entry layout: {illegal, tag, imm}
    localparam int EW = XLEN + TAG_W + 1;

    occ_e            state_q, state_d;
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic [EW-1:0]   new_ent;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;
    logic            acc;
    logic            con;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (inst),
        .imm_sel (imm_sel)
`ifdef IMM_ILLEGAL_CHECK_EN
        ,
        .illegal (dec_ill)
`endif
        ,
        .imm     (dec_imm)
    );

`ifndef IMM_ILLEGAL_CHECK_EN
    assign dec_ill = 1'b0;
`endif

    assign new_ent   = {dec_ill, tag_in, dec_imm};
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid && in_ready;
    assign con       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        head_d  = new_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && con) begin
                        head_d = new_ent;
                    end else if (acc) begin
                        skid_d  = new_ent;
                        state_d = ST_FULL;
                    end else if (con) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a consume can move the state.
                    if (con) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign imm_ext = head_q[XLEN-1:0];
    assign tag_out = head_q[XLEN +: TAG_W];

`ifdef IMM_ILLEGAL_CHECK_EN
    assign illegal = head_q[EW-1];
`else
    logic unused_ill;
    assign unused_ill = head_q[EW-1];
`endif

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 32, width of a sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, an upstream instruction is presented.
REQ-007 SHALL have port in_ready, output, 1, the block accepts the instruction this cycle.
REQ-008 SHALL have port inst, input, 32, the raw instruction word.
REQ-009 SHALL have port imm_sel, input, 4, where bit 3 selects unsigned and bits [2:0] select the immediate type.
REQ-010 SHALL have port tag_in, input, TAG_W, sideband data accompanying inst.
REQ-011 SHALL have port out_valid, output, 1, imm_ext and tag_out are valid.
REQ-012 SHALL have port out_ready, input, 1, the downstream consumes the output this cycle.
REQ-013 SHALL have port imm_ext, output, XLEN, the extended immediate.
REQ-014 SHALL have port tag_out, output, TAG_W, the tag paired with imm_ext.

Function
REQ-015 SHALL decode, by type: 1 U {inst[31:12],12'b0}; 2 J {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}; 3 I inst[31:20]; 4 B {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; 5 S {inst[31:25],inst[11:7]}; 6 shift amount inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
REQ-016 SHALL sign-extend types 1-5 from their MSB to XLEN when imm_sel[3]=0, and zero-extend them when imm_sel[3]=1; type 6 SHALL always be zero-extended.
REQ-017 SHALL output all-zero for type codes 0 and 7.
REQ-018 SHALL accept an instruction on a cycle with in_valid && in_ready, and present its result on out_valid exactly 1 cycle later when the buffer was empty.
REQ-019 SHALL hold a 2-entry FIFO (skid buffer) with occupancy states EMPTY, ONE and FULL; accept-only SHALL advance the state by one, consume-only SHALL retreat it by one, and accept and consume in the same cycle SHALL leave it unchanged.
REQ-020 SHALL drive in_ready = (state != FULL), derived from state only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (state != EMPTY), and SHALL hold imm_ext and tag_out stable while out_valid && !out_ready.
REQ-022 SHALL deliver results in acceptance order, with no loss or duplication across ONE->FULL->ONE transitions.
REQ-023 SHALL give flush priority over simultaneous accept and consume: the state goes to EMPTY and the same-cycle input is dropped.
REQ-024 SHALL perform no state change when in_valid=1 while FULL, and the input SHALL be held by upstream.

Reset
REQ-025 SHALL, on reset, set state to EMPTY and out_valid=0, with imm_ext, tag_out and all stored entries set to 0.
REQ-026 SHALL give reset priority over flush and handshakes, and SHALL discard any in-flight entry on reset mid-operation.
REQ-027 SHALL assert in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, when IMM_ILLEGAL_CHECK_EN is defined, add output illegal (1 bit), registered with each entry and asserted alongside out_valid when the type code was 0 or 7, or when XLEN=32 and type 6 had inst[25]=1; without the macro the port SHALL be absent and the behaviour otherwise identical.

Structure
REQ-029 SHALL take the type codes IMM_TYPE1..IMM_TYPE6 (3'd1..3'd6), the unsigned-bit index and the state encodings from the shared encodings include, never from literals in the module.
REQ-030 SHALL contain the combinational decoder as sub-module imm_decode (parameter XLEN), instantiated once on the input side.

Verification
REQ-031 SHALL cover: XLEN=32, inst=32'hFFF00093, imm_sel=4'b0011 -> imm_ext=32'hFFFFFFFF one cycle later; with imm_sel=4'b1011 -> 32'h00000FFF.
REQ-032 SHALL cover: B-type inst=32'hFE000EE3, signed -> imm_ext=32'hFFFFFFFC; XLEN=64 -> 64'hFFFFFFFFFFFFFFFC.
REQ-033 SHALL cover: out_ready=0 while 3 back-to-back valids are sent -> in_ready falls after 2 accepts; releasing out_ready yields tags T0,T1,T2 in order.
REQ-034 SHALL cover: FULL with in_valid=1, out_ready=1 and flush=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and nothing is emitted.
REQ-035 SHALL cover: reset asserted while ONE -> next cycle out_valid=0 and imm_ext=0.
REQ-036 SHALL cover: with IMM_ILLEGAL_CHECK_EN, imm_sel=4'b0111 -> imm_ext=0 and illegal=1.
